// File: rtl/debouncer_multi.sv
// debouncer_multi: N_CH independent debouncers for keypad and door switches.
// Each channel has a SYNC_STAGES-deep synchroniser and a stable-time counter.
// It drives registered rise/fall pulses and an optional auto-repeat pulse train
// while the debounced level is high. The repeat output is named repeat_o
// because "repeat" is a reserved word in SystemVerilog.
// dbg_held_o shows each channel's auto-repeat FSM state (1 = HELD). It is
// tied to 0 when auto-repeat is disabled (REPEAT_DELAY == 0).
module debouncer_multi #(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 1000,
  parameter int SYNC_STAGES   = 2,
  parameter int REP_W         = 24,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] noisy,
  output logic [N_CH-1:0] debounced,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] repeat_o,
  output logic [N_CH-1:0] dbg_held_o,
  output logic            any_active
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } rep_state_e;

  localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CYCLES - 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   toggle;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain; the raw input enters at bit 0.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], noisy[i]};
    end

    // Count consecutive disagreement cycles; flip the level when the count
    // reaches the threshold. Any cycle of agreement restarts the count.
    always_comb begin
      cnt_d  = cnt_q;
      deb_d  = deb_q;
      toggle = 1'b0;
      if (sync_bit == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == STABLE_M1) begin
        toggle = 1'b1;
        deb_d  = ~deb_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      rise_d = toggle & ~deb_q;
      fall_d = toggle & deb_q;
    end

    // Level, counter and edge-pulse registers; the pulses appear with the new level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        deb_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        deb_q  <= deb_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign debounced[i] = deb_q;
    assign rise[i]      = rise_q;
    assign fall[i]      = fall_q;

    if (REPEAT_DELAY > 0) begin : g_rep
      localparam logic [REP_W-1:0] DLY_M1 = REP_W'(REPEAT_DELAY - 1);
      localparam logic [REP_W-1:0] PER_M1 = REP_W'(REPEAT_PERIOD - 1);

      rep_state_e       state_q, state_d;
      logic [REP_W-1:0] rcnt_q, rcnt_d;
      logic             first_q, first_d;
      logic             rep_q, rep_d;

      // Auto-repeat FSM. first_q selects REPEAT_DELAY as the target before the
      // first pulse and REPEAT_PERIOD after it. A falling level always wins,
      // so no repeat pulse is produced in the same cycle as a fall.
      always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        first_d = first_q;
        rep_d   = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (rise_d) begin
              state_d = ST_HELD;
              rcnt_d  = '0;
              first_d = 1'b1;
            end
          end
          ST_HELD: begin
            if (fall_d) begin
              state_d = ST_IDLE;
              rcnt_d  = '0;
              first_d = 1'b1;
            end else if (rcnt_q == (first_q ? DLY_M1 : PER_M1)) begin
              rep_d   = 1'b1;
              rcnt_d  = '0;
              first_d = 1'b0;
            end else begin
              rcnt_d = rcnt_q + REP_W'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
            first_d = 1'b1;
          end
        endcase
      end

      // Auto-repeat state register and registered repeat pulse.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= ST_IDLE;
          rcnt_q  <= '0;
          first_q <= 1'b1;
          rep_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
          first_q <= first_d;
          rep_q   <= rep_d;
        end
      end

      assign repeat_o[i]   = rep_q;
      assign dbg_held_o[i] = (state_q == ST_HELD);
    end else begin : g_norep
      assign repeat_o[i]   = 1'b0;
      assign dbg_held_o[i] = 1'b0;
    end
  end

  assign any_active = |debounced;

endmodule
